// File: rtl/prils_seq.sv
// prils_seq: Moore sequencer driving the mux selects of the FPU priority-encode /
// left-shift normalization datapath. Define PRILS_SEQ_ABS_EN to make op 5 (NORM_ABS) legal.
module prils_seq (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       req_val,
  input  logic [2:0] req_op,
  input  logic       req_dprec,
  input  logic [1:0] req_const,
  input  logic       flush,
  input  logic [5:0] priout,
  output logic       req_rdy,
  output logic       m0c,
  output logic [1:0] m1c,
  output logic [1:0] m2c,
  output logic [1:0] m3c,
  output logic [1:0] mconfunc,
  output logic       m4,
  output logic       lsdprec,
  output logic       done,
  output logic [5:0] norm_cnt,
  output logic       zero,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRI_HI   = 3'd1,
    PRI_LO   = 3'd2,
    SHIFT_HI = 3'd3,
    SHIFT_LO = 3'd4,
    OUT      = 3'd5
  } state_t;

  localparam logic [2:0] OP_NORM_S   = 3'd0;
  localparam logic [2:0] OP_NORM_D   = 3'd1;
  localparam logic [2:0] OP_SHIFT    = 3'd2;
  localparam logic [2:0] OP_CONST    = 3'd3;
  localparam logic [2:0] OP_MULT     = 3'd4;
  localparam logic [2:0] OP_NORM_ABS = 3'd5;

`ifdef PRILS_SEQ_ABS_EN
  localparam logic ABS_EN = 1'b1;
`else
  localparam logic ABS_EN = 1'b0;
`endif

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_NORM_S, OP_NORM_D, OP_SHIFT, OP_CONST, OP_MULT: ok = 1'b1;
      OP_NORM_ABS: ok = ABS_EN;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t     state_r, state_nf_s, state_s;
  logic [2:0] op_r, op_s;
  logic [1:0] const_r, const_s;
  logic       accept_s;
  logic       p_zero_s;
  logic [6:0] sum_s;
  logic [5:0] lo_cnt_s;
  logic [1:0] hi_sel_s;
  logic       m0c_s, m4_s, done_s;
  logic [1:0] m1c_s, m2c_s, m3c_s, mconfunc_s;

  assign accept_s = req_val && req_rdy && !flush;
  assign p_zero_s = (priout == 6'd32);
  assign sum_s    = 7'd32 + {1'b0, priout};
  assign state_s  = flush ? IDLE : state_nf_s;

  // Low-word count: saturate at 63 when both words were zero on a double op
  always_comb begin
    lo_cnt_s = priout;
    if (op_r == OP_NORM_S) begin
      lo_cnt_s = priout;
    end else if (sum_s[6]) begin
      lo_cnt_s = 6'd63;
    end else begin
      lo_cnt_s = sum_s[5:0];
    end
  end

  // Next-state logic and latched-op capture
  always_comb begin
    state_nf_s = state_r;
    op_s       = op_r;
    const_s    = const_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          op_s    = req_op;
          const_s = req_const;
          case (req_op)
            OP_NORM_S:                   state_nf_s = PRI_LO;
            OP_NORM_D:                   state_nf_s = PRI_HI;
            OP_NORM_ABS:                 state_nf_s = ABS_EN ? PRI_HI : IDLE;
            OP_SHIFT, OP_CONST, OP_MULT: state_nf_s = OUT;
            default:                     state_nf_s = IDLE;
          endcase
        end else begin
          state_nf_s = IDLE;
        end
      end
      PRI_HI:   state_nf_s = p_zero_s ? PRI_LO : SHIFT_HI;
      PRI_LO:   state_nf_s = p_zero_s ? OUT : SHIFT_LO;
      SHIFT_HI: state_nf_s = IDLE;
      SHIFT_LO: state_nf_s = IDLE;
      OUT:      state_nf_s = IDLE;
      default:  state_nf_s = IDLE;
    endcase
  end

  // Select decode of the upcoming state, so the registered selects line up with the state
  always_comb begin
    m0c_s      = 1'b0;
    m1c_s      = 2'b00;
    m2c_s      = 2'b00;
    m3c_s      = 2'b00;
    mconfunc_s = 2'b00;
    m4_s       = 1'b0;
    done_s     = 1'b0;
    hi_sel_s   = ((op_s == OP_NORM_ABS) && ABS_EN) ? 2'b11 : 2'b01;
    case (state_s)
      IDLE:   done_s = 1'b0;
      PRI_HI: m1c_s  = hi_sel_s;
      PRI_LO: m1c_s  = 2'b00;
      SHIFT_HI: begin
        m1c_s  = hi_sel_s;
        m0c_s  = 1'b1;
        m2c_s  = 2'b10;
        m3c_s  = 2'b10;
        done_s = 1'b1;
      end
      SHIFT_LO: begin
        m2c_s  = 2'b10;
        m3c_s  = 2'b10;
        done_s = 1'b1;
      end
      OUT: begin
        done_s = 1'b1;
        case (op_s)
          OP_SHIFT: begin
            m0c_s = 1'b1;
            m2c_s = 2'b01;
            m3c_s = 2'b10;
          end
          OP_CONST: begin
            m3c_s      = 2'b01;
            mconfunc_s = const_s;
          end
          OP_MULT: m4_s  = 1'b1;
          default: m3c_s = 2'b00;
        endcase
      end
      default: done_s = 1'b0;
    endcase
  end

  // State, latched request fields and registered outputs
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r  <= IDLE;
      op_r     <= 3'd0;
      const_r  <= 2'b00;
      req_rdy  <= 1'b1;
      m0c      <= 1'b0;
      m1c      <= 2'b00;
      m2c      <= 2'b00;
      m3c      <= 2'b00;
      mconfunc <= 2'b00;
      m4       <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      lsdprec  <= 1'b0;
    end else begin
      state_r  <= state_s;
      op_r     <= op_s;
      const_r  <= const_s;
      req_rdy  <= (state_s == IDLE);
      m0c      <= m0c_s;
      m1c      <= m1c_s;
      m2c      <= m2c_s;
      m3c      <= m3c_s;
      mconfunc <= mconfunc_s;
      m4       <= m4_s;
      done     <= done_s;
      err      <= accept_s && !op_legal(req_op);
      if (accept_s) begin
        lsdprec <= req_dprec;
      end
    end
  end

  // Normalization count and zero flag; flush freezes them
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      norm_cnt <= 6'd0;
      zero     <= 1'b0;
    end else if (accept_s) begin
      norm_cnt <= 6'd0;
      zero     <= 1'b0;
    end else if (!flush && (state_r == PRI_HI)) begin
      norm_cnt <= priout;
    end else if (!flush && (state_r == PRI_LO)) begin
      norm_cnt <= lo_cnt_s;
      zero     <= p_zero_s;
    end
  end

endmodule

// File: tb/tb_prils_seq.sv
// Self-checking bench for prils_seq: scoreboard of expected done-cycle results plus
// directed checks for reset, flush and illegal ops.
module tb_prils_seq;

  logic       clk = 1'b0;
  logic       reset_l, req_val, req_dprec, flush;
  logic [2:0] req_op;
  logic [1:0] req_const;
  logic [5:0] priout;
  logic       req_rdy, m0c, m4, lsdprec, done, zero, err;
  logic [1:0] m1c, m2c, m3c, mconfunc;
  logic [5:0] norm_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int         lat;
    logic [9:0] sel;
    logic [5:0] cnt;
    logic       zero;
    logic       dp;
  } exp_t;

  exp_t sbq[$];

  prils_seq dut (
    .clk(clk), .reset_l(reset_l), .req_val(req_val), .req_op(req_op),
    .req_dprec(req_dprec), .req_const(req_const), .flush(flush), .priout(priout),
    .req_rdy(req_rdy), .m0c(m0c), .m1c(m1c), .m2c(m2c), .m3c(m3c),
    .mconfunc(mconfunc), .m4(m4), .lsdprec(lsdprec), .done(done),
    .norm_cnt(norm_cnt), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] sel_now();
    return {m0c, m1c, m2c, m3c, mconfunc, m4};
  endfunction

  function automatic logic [20:0] all_outs();
    return {req_rdy, m0c, m1c, m2c, m3c, mconfunc, m4, lsdprec, done, norm_cnt, zero, err};
  endfunction

  // Reference model: {m0c,m1c,m2c,m3c,mconfunc,m4} in the done cycle
  function automatic exp_t model(input logic [2:0] op, input logic dp, input logic [1:0] cs,
                                 input logic [5:0] phi, input logic [5:0] plo);
    exp_t e;
    e.lat = 1; e.sel = 10'b0; e.cnt = 6'd0; e.zero = 1'b0; e.dp = dp;
    case (op)
      3'd0: begin
        e.lat = 2;
        if (plo == 6'd32) begin e.cnt = 6'd32; e.zero = 1'b1; end
        else begin e.cnt = plo; e.sel = {1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0}; end
      end
      3'd1: begin
        if (phi != 6'd32) begin
          e.lat = 2; e.cnt = phi; e.sel = {1'b1, 2'b01, 2'b10, 2'b10, 2'b00, 1'b0};
        end else begin
          e.lat = 3;
          if (plo == 6'd32) begin e.cnt = 6'd63; e.zero = 1'b1; end
          else begin e.cnt = 6'd32 + plo; e.sel = {1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0}; end
        end
      end
      3'd2: e.sel = {1'b1, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
      3'd3: e.sel = {1'b0, 2'b00, 2'b00, 2'b01, cs, 1'b0};
      3'd4: e.sel = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
      default: e.lat = 0;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic dp, input logic [1:0] cs,
                        input logic [5:0] phi, input logic [5:0] plo);
    exp_t e;
    bit   got;
    sbq.push_back(model(op, dp, cs, phi, plo));
    chk("rdy_before", req_rdy, 1);
    req_val = 1'b1; req_op = op; req_dprec = dp; req_const = cs;
    tick();
    req_val = 1'b0; req_op = 3'd0; req_dprec = 1'b0; req_const = 2'b00;
    got = 1'b0;
    for (int k = 1; k <= 6 && !got; k++) begin
      priout = (k == 1 && op != 3'd0) ? phi : plo;
      if (done) begin
        got = 1'b1;
        e = sbq.pop_front();
        chk("latency", k, e.lat);
        chk("sel", sel_now(), e.sel);
        chk("norm_cnt", norm_cnt, e.cnt);
        chk("zero", zero, e.zero);
        chk("lsdprec", lsdprec, e.dp);
      end else begin
        tick();
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      e = sbq.pop_front();
    end
    tick();
    chk("done_pulse", done, 0);
    chk("rdy_after", req_rdy, 1);
  endtask

  task automatic illegal_op(input logic [2:0] op);
    req_val = 1'b1; req_op = op;
    tick();
    req_val = 1'b0; req_op = 3'd0;
    chk("err_pulse", err, 1);
    chk("err_nodone", done, 0);
    chk("err_idle", req_rdy, 1);
    tick();
    chk("err_clear", err, 0);
    chk("err_nodone2", done, 0);
  endtask

  initial begin
    reset_l = 1'b0; req_val = 1'b0; req_op = 3'd0; req_dprec = 1'b0;
    req_const = 2'b00; flush = 1'b0; priout = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vals", all_outs(), {1'b1, 20'd0});
    reset_l = 1'b1;
    tick();

    run_op(3'd1, 1'b1, 2'b00, 6'd5,  6'd0);
    run_op(3'd1, 1'b0, 2'b00, 6'd32, 6'd7);
    run_op(3'd0, 1'b1, 2'b00, 6'd0,  6'd32);
    run_op(3'd0, 1'b0, 2'b00, 6'd0,  6'd12);
    run_op(3'd1, 1'b1, 2'b00, 6'd32, 6'd32);
    run_op(3'd1, 1'b0, 2'b00, 6'd32, 6'd31);
    run_op(3'd1, 1'b0, 2'b00, 6'd0,  6'd0);
    run_op(3'd2, 1'b1, 2'b00, 6'd0,  6'd0);
    run_op(3'd3, 1'b0, 2'b01, 6'd0,  6'd0);
    run_op(3'd3, 1'b1, 2'b11, 6'd0,  6'd0);
    run_op(3'd4, 1'b0, 2'b00, 6'd0,  6'd0);

`ifndef PRILS_SEQ_ABS_EN
    illegal_op(3'd5);
`endif
    illegal_op(3'd7);

    // flush while in PRI_LO
    req_val = 1'b1; req_op = 3'd1; req_dprec = 1'b0;
    tick();
    req_val = 1'b0; req_op = 3'd0; priout = 6'd32;
    chk("fl_prihi_m1c", m1c, 2'b01);
    chk("fl_busy", req_rdy, 0);
    tick();
    chk("fl_prilo_m1c", m1c, 2'b00);
    chk("fl_cnt_hi", norm_cnt, 6'd32);
    flush = 1'b1; priout = 6'd7;
    tick();
    flush = 1'b0;
    chk("fl_nodone", done, 0);
    chk("fl_idle", req_rdy, 1);
    chk("fl_cnt_hold", norm_cnt, 6'd32);
    chk("fl_zero_hold", zero, 0);
    tick();
    chk("fl_nodone2", done, 0);

    // asynchronous reset while in PRI_HI
    req_val = 1'b1; req_op = 3'd1; req_dprec = 1'b1;
    tick();
    req_val = 1'b0; req_op = 3'd0; req_dprec = 1'b0; priout = 6'd5;
    chk("rm_busy", req_rdy, 0);
    chk("rm_dprec", lsdprec, 1);
    #2;
    reset_l = 1'b0;
    #1;
    chk("rm_async", all_outs(), {1'b1, 20'd0});
    tick();
    chk("rm_held", all_outs(), {1'b1, 20'd0});
    reset_l = 1'b1;
    tick();
    chk("rm_rdy", req_rdy, 1);
    chk("rm_nodone", done, 0);

    run_op(3'd0, 1'b0, 2'b00, 6'd0, 6'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
